// File: rtl/sram_controller_if.sv
// Pipeline-side bus of the SRAM controller: MEM-stage requests in,
// load data and the pipeline-freeze handshake out.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  wr_en, rd_en, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// SRAM controller: turns one 32-bit MEM-stage load/store into two 16-bit
// SRAM accesses (low halfword, then high halfword), followed by a fixed
// number of idle cycles. ready stays low for the whole transaction so the
// pipeline freezes, and goes high for exactly one cycle in DONE.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  inout  wire  [15:0]      SRAM_DQ,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_WE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N
);

  typedef enum logic [2:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        op_rd_q;
  logic [31:0] read_data_q;
  logic [3:0]  wait_cnt;
  logic [31:0] offset;
  logic [16:0] word_index;
  logic        accept;
  logic        dq_drive;
  logic [15:0] dq_out;
  logic        unused_offset_bits;

  // Word index relative to the SRAM window; wraps modulo 2^17 words and
  // ignores the byte-within-word bits.
  assign offset             = addr_q - 32'(BASE_ADDR);
  assign word_index         = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // A request is only taken while idle; DONE always returns to IDLE first.
  assign accept = (state == IDLE) && (bus.rd_en || bus.wr_en);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request so later input changes cannot disturb the access;
  // a read wins when both enables are high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      op_rd_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.address;
      data_q  <= bus.writeData;
      op_rd_q <= bus.rd_en;
    end
  end

  // Load data assembles halfword by halfword; writes never touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
    end else if (op_rd_q && (state == ACC_LO)) begin
      read_data_q[15:0] <= SRAM_DQ;
    end else if (op_rd_q && (state == ACC_HI)) begin
      read_data_q[31:16] <= SRAM_DQ;
    end
  end

  // Idle-cycle counter, running only while in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Next-state and SRAM/handshake outputs.
  always_comb begin
    state_next = state;
    bus.ready  = 1'b0;
    SRAM_ADDR  = '0;
    dq_drive   = 1'b0;
    dq_out     = '0;
    case (state)
      IDLE: begin
        bus.ready = ~(bus.rd_en | bus.wr_en);
        if (bus.rd_en || bus.wr_en) begin
          state_next = ACC_LO;
        end
      end
      ACC_LO: begin
        SRAM_ADDR  = {word_index, 1'b0};
        dq_drive   = ~op_rd_q;
        dq_out     = data_q[15:0];
        state_next = ACC_HI;
      end
      ACC_HI: begin
        SRAM_ADDR  = {word_index, 1'b1};
        dq_drive   = ~op_rd_q;
        dq_out     = data_q[31:16];
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.ready  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign SRAM_DQ      = dq_drive ? dq_out : 16'hzzzz;
  assign SRAM_WE_N    = ~dq_drive;
  assign SRAM_OE_N    = dq_drive;
  assign SRAM_CE_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;
  assign bus.readData = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a default instance (WAIT_CYCLES=3) and a
// WAIT_CYCLES=1 instance, each with a simple SRAM model on its data bus.
// Expected values are queued when stimulus is driven and popped as the
// DUT produces its outputs.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sram_controller_if bus0 ();
  sram_controller_if bus1 ();

  wire  [15:0] dq0;
  wire  [15:0] dq1;
  logic [17:0] addr0, addr1;
  logic        we_n0, ub_n0, lb_n0, ce_n0, oe_n0;
  logic        we_n1, ub_n1, lb_n1, ce_n1, oe_n1;

  sram_controller dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0),
    .SRAM_DQ   (dq0),
    .SRAM_ADDR (addr0),
    .SRAM_WE_N (we_n0),
    .SRAM_UB_N (ub_n0),
    .SRAM_LB_N (lb_n0),
    .SRAM_CE_N (ce_n0),
    .SRAM_OE_N (oe_n0)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .SRAM_DQ   (dq1),
    .SRAM_ADDR (addr1),
    .SRAM_WE_N (we_n1),
    .SRAM_UB_N (ub_n1),
    .SRAM_LB_N (lb_n1),
    .SRAM_CE_N (ce_n1),
    .SRAM_OE_N (oe_n1)
  );

  // SRAM models: drive the bus on reads, store on WE_N low at the clock edge.
  // probe0 forces 0 onto dq0 to show the DUT has released the bus.
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  logic        probe0 = 1'b0;
  wire         unused_tb = ^{addr1[17:8], ub_n1, lb_n1, ce_n1};

  assign dq0 = probe0 ? 16'h0000 :
               ((!oe_n0 && we_n0) ? mem0[addr0[7:0]] : 16'hzzzz);
  assign dq1 = (!oe_n1 && we_n1) ? mem1[addr1[7:0]] : 16'hzzzz;

  always @(posedge clk) if (!we_n0) mem0[addr0[7:0]] <= dq0;
  always @(posedge clk) if (!we_n1) mem1[addr1[7:0]] <= dq1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic        rdy_req, we_lo, we_hi, oe_lo, we_late;
  logic [17:0] addr_lo, addr_hi;
  logic [15:0] dq_lo, dq_hi, dq_wait;
  logic [31:0] rd_data;
  int          lat;

  task automatic push_expected(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<none>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
      end
    end
  endtask

  // One full access on dut0: request for one cycle, then scrambled inputs,
  // recording what the SRAM side shows in each phase and the latency.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus0.rd_en = rd; bus0.wr_en = wr; bus0.address = addr; bus0.writeData = data;
    #1 rdy_req = bus0.ready;
    @(negedge clk);
    addr_lo = addr0; dq_lo = dq0; we_lo = we_n0; oe_lo = oe_n0;
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0;
    bus0.address = ~addr; bus0.writeData = ~data;
    @(negedge clk);
    addr_hi = addr0; dq_hi = dq0; we_hi = we_n0;
    lat = 2; we_late = 1'b0; dq_wait = 16'hffff;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        probe0 = 1'b1;
        #1 dq_wait = dq0;
        probe0 = 1'b0;
      end
      if (!we_n0) we_late = 1'b1;
      if (bus0.ready) break;
    end
    rd_data = bus0.readData;
  endtask

  initial begin
    int n;
    bus0.rd_en = 0; bus0.wr_en = 0; bus0.address = 0; bus0.writeData = 0;
    bus1.rd_en = 0; bus1.wr_en = 0; bus1.address = 0; bus1.writeData = 0;

    // Reset state.
    #2 rst = 1'b0;
    push_expected("rst_ready", 1);
    push_expected("rst_readData", 0);
    push_expected("rst_sram_addr", 0);
    push_expected("rst_we_n", 1);
    push_expected("rst_oe_n", 0);
    push_expected("rst_ce_ub_lb", 0);
    push_expected("rst_dq_released", 0);
    #10 probe0 = 1'b1;
    #1;
    checkOutput(bus0.ready); checkOutput(bus0.readData); checkOutput(addr0);
    checkOutput(we_n0); checkOutput(oe_n0); checkOutput({ce_n0, ub_n0, lb_n0});
    checkOutput(dq0);
    probe0 = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Write 0xDEADBEEF at the base address.
    push_expected("wr_req_ready", 0);
    push_expected("wr_lo_addr", 0);
    push_expected("wr_lo_dq", 32'hbeef);
    push_expected("wr_lo_we_n", 0);
    push_expected("wr_lo_oe_n", 1);
    push_expected("wr_hi_addr", 1);
    push_expected("wr_hi_dq", 32'hdead);
    push_expected("wr_hi_we_n", 0);
    push_expected("wr_wait_dq_released", 0);
    push_expected("wr_no_late_we", 0);
    push_expected("wr_latency", 6);
    push_expected("wr_readData_kept", 0);
    push_expected("wr_idle_ready", 1);
    push_expected("wr_mem_lo", 32'hbeef);
    push_expected("wr_mem_hi", 32'hdead);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'hdeadbeef);
    checkOutput(rdy_req); checkOutput(addr_lo); checkOutput(dq_lo);
    checkOutput(we_lo); checkOutput(oe_lo); checkOutput(addr_hi);
    checkOutput(dq_hi); checkOutput(we_hi); checkOutput(dq_wait);
    checkOutput(we_late); checkOutput(lat); checkOutput(rd_data);
    @(negedge clk);
    checkOutput(bus0.ready); checkOutput(mem0[0]); checkOutput(mem0[1]);

    // Read it back.
    push_expected("rd_req_ready", 0);
    push_expected("rd_lo_addr", 0);
    push_expected("rd_lo_we_n", 1);
    push_expected("rd_hi_addr", 1);
    push_expected("rd_no_late_we", 0);
    push_expected("rd_latency", 6);
    push_expected("rd_readData", 32'hdeadbeef);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
    checkOutput(rdy_req); checkOutput(addr_lo); checkOutput(we_lo);
    checkOutput(addr_hi); checkOutput(we_late); checkOutput(lat);
    checkOutput(rd_data);

    // Offset past the 2^17-word window wraps back to word 2.
    push_expected("wrap_lo_addr", 4);
    push_expected("wrap_lo_dq", 32'h5678);
    push_expected("wrap_hi_addr", 5);
    push_expected("wrap_hi_dq", 32'h1234);
    push_expected("wrap_latency", 6);
    applyStimulus(1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131072 + 32'd8, 32'h12345678);
    checkOutput(addr_lo); checkOutput(dq_lo); checkOutput(addr_hi);
    checkOutput(dq_hi); checkOutput(lat);

    // Store a word at 1028, then issue read and write together there.
    push_expected("w1028_lo_addr", 2);
    push_expected("w1028_latency", 6);
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'hcafef00d);
    checkOutput(addr_lo); checkOutput(lat);

    push_expected("both_lo_we_n", 1);
    push_expected("both_hi_we_n", 1);
    push_expected("both_no_late_we", 0);
    push_expected("both_latency", 6);
    push_expected("both_readData", 32'hcafef00d);
    push_expected("both_mem_lo_kept", 32'hf00d);
    push_expected("both_mem_hi_kept", 32'hcafe);
    applyStimulus(1'b1, 1'b1, 32'd1028, 32'h0badc0de);
    checkOutput(we_lo); checkOutput(we_hi); checkOutput(we_late);
    checkOutput(lat); checkOutput(rd_data);
    checkOutput(mem0[2]); checkOutput(mem0[3]);

    // Known contents at 1040, then a write there aborted by reset in ACC_LO.
    push_expected("w1040_latency", 6);
    applyStimulus(1'b0, 1'b1, 32'd1040, 32'haaaa5555);
    checkOutput(lat);

    push_expected("abort_lo_we_n", 0);
    push_expected("abort_we_n", 1);
    push_expected("abort_dq_released", 0);
    push_expected("abort_sram_addr", 0);
    push_expected("abort_readData", 0);
    push_expected("abort_ready", 1);
    @(negedge clk);
    bus0.wr_en = 1'b1; bus0.address = 32'd1040; bus0.writeData = 32'h11112222;
    @(negedge clk);
    checkOutput(we_n0);
    rst = 1'b0; bus0.wr_en = 1'b0; probe0 = 1'b1;
    #1;
    checkOutput(we_n0); checkOutput(dq0); checkOutput(addr0);
    checkOutput(bus0.readData); checkOutput(bus0.ready);
    probe0 = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_expected($sformatf("post_abort_ready_%0d", i), 1);
      push_expected($sformatf("post_abort_we_n_%0d", i), 1);
      @(negedge clk);
      checkOutput(bus0.ready); checkOutput(we_n0);
    end
    push_expected("abort_mem_lo_kept", 32'h5555);
    push_expected("abort_mem_hi_kept", 32'haaaa);
    checkOutput(mem0[8]); checkOutput(mem0[9]);

    // WAIT_CYCLES=1 instance: write, then back-to-back reads held through DONE.
    push_expected("w1_write_latency", 4);
    @(negedge clk);
    bus1.wr_en = 1'b1; bus1.address = 32'd1024; bus1.writeData = 32'h600df00d;
    @(negedge clk);
    bus1.wr_en = 1'b0;
    n = 1;
    while (!bus1.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(n);

    push_expected("b2b_first_req_ready", 0);
    push_expected("b2b_first_latency", 4);
    push_expected("b2b_first_readData", 32'h600df00d);
    push_expected("b2b_second_req_ready", 0);
    push_expected("b2b_second_idle_addr", 0);
    push_expected("b2b_second_latency", 4);
    push_expected("b2b_second_readData", 32'h600df00d);
    @(negedge clk);
    bus1.rd_en = 1'b1; bus1.address = 32'd1024;
    #1 checkOutput(bus1.ready);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.ready && n < 40);
    checkOutput(n); checkOutput(bus1.readData);
    @(negedge clk);
    checkOutput(bus1.ready); checkOutput(addr1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.ready && n < 40);
    checkOutput(n); checkOutput(bus1.readData);
    bus1.rd_en = 1'b0;

    // Every queued expectation must have been consumed.
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
